// File: rtl/sine_lookup.sv
// Two-stage quarter-wave sine lookup, phase in / offset-binary sample out.
// Define SINE_AMP_SHIFT_EN to add the amp_shift attenuation input.
module sine_lookup #(
    parameter logic [7:0] ZERO_CODE = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] phase,
`ifdef SINE_AMP_SHIFT_EN
    input  logic [2:0] amp_shift,
`endif
    output logic       in_ready,
    output logic [7:0] dout,
    output logic       out_valid,
    input  logic       out_ready
);

    function automatic logic [6:0] sine_tab(input logic [6:0] a);
        logic [6:0] t;
        t = 7'd0;
        case (a)
            7'd1:  t = 7'd3;   7'd2:  t = 7'd6;   7'd3:  t = 7'd9;   7'd4:  t = 7'd12;
            7'd5:  t = 7'd16;  7'd6:  t = 7'd19;  7'd7:  t = 7'd22;  7'd8:  t = 7'd25;
            7'd9:  t = 7'd28;  7'd10: t = 7'd31;  7'd11: t = 7'd34;  7'd12: t = 7'd37;
            7'd13: t = 7'd40;  7'd14: t = 7'd43;  7'd15: t = 7'd46;  7'd16: t = 7'd49;
            7'd17: t = 7'd51;  7'd18: t = 7'd54;  7'd19: t = 7'd57;  7'd20: t = 7'd60;
            7'd21: t = 7'd63;  7'd22: t = 7'd65;  7'd23: t = 7'd68;  7'd24: t = 7'd71;
            7'd25: t = 7'd73;  7'd26: t = 7'd76;  7'd27: t = 7'd78;  7'd28: t = 7'd81;
            7'd29: t = 7'd83;  7'd30: t = 7'd85;  7'd31: t = 7'd88;  7'd32: t = 7'd90;
            7'd33: t = 7'd92;  7'd34: t = 7'd94;  7'd35: t = 7'd96;  7'd36: t = 7'd98;
            7'd37: t = 7'd100; 7'd38: t = 7'd102; 7'd39: t = 7'd104; 7'd40: t = 7'd106;
            7'd41: t = 7'd107; 7'd42: t = 7'd109; 7'd43: t = 7'd111; 7'd44: t = 7'd112;
            7'd45: t = 7'd113; 7'd46: t = 7'd115; 7'd47: t = 7'd116; 7'd48: t = 7'd117;
            7'd49: t = 7'd118; 7'd50: t = 7'd120; 7'd51: t = 7'd121; 7'd52: t = 7'd122;
            7'd53: t = 7'd122; 7'd54: t = 7'd123; 7'd55: t = 7'd124; 7'd56: t = 7'd125;
            7'd57: t = 7'd125; 7'd58: t = 7'd126; 7'd59: t = 7'd126; 7'd60: t = 7'd126;
            7'd61: t = 7'd127; 7'd62: t = 7'd127; 7'd63: t = 7'd127; 7'd64: t = 7'd127;
            default: t = 7'd0;
        endcase
        return t;
    endfunction

    logic              advance;
    logic [6:0]        addr_q, addr_d;
    logic              neg_q, neg_d;
    logic              v1_q, v1_d;
    logic [7:0]        dout_q, dout_d;
    logic              ov_q, ov_d;
    logic [6:0]        mag;
    logic signed [7:0] s;
    logic signed [7:0] s_sh;
`ifdef SINE_AMP_SHIFT_EN
    logic [2:0]        sh_q, sh_d;
`endif

    always_comb begin
        advance = !ov_q || out_ready;
        addr_d  = addr_q;
        neg_d   = neg_q;
        v1_d    = v1_q;
        dout_d  = dout_q;
        ov_d    = ov_q;
        mag     = sine_tab(addr_q);
        // Magnitude is at most 127, so the signed sample fits in 8 bits.
        s       = neg_q ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
`ifdef SINE_AMP_SHIFT_EN
        sh_d    = sh_q;
        s_sh    = s >>> sh_q;
`else
        s_sh    = s;
`endif
        if (advance) begin
            addr_d = phase[6] ? 7'd64 - {1'b0, phase[5:0]} : {1'b0, phase[5:0]};
            neg_d  = phase[7];
            v1_d   = in_valid;
`ifdef SINE_AMP_SHIFT_EN
            sh_d   = amp_shift;
`endif
            // True sum stays within 0..255, so the 8-bit add never wraps.
            dout_d = ZERO_CODE + $unsigned(s_sh);
            ov_d   = v1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= 7'd0;
            neg_q  <= 1'b0;
            v1_q   <= 1'b0;
            dout_q <= ZERO_CODE;
            ov_q   <= 1'b0;
`ifdef SINE_AMP_SHIFT_EN
            sh_q   <= 3'd0;
`endif
        end else begin
            addr_q <= addr_d;
            neg_q  <= neg_d;
            v1_q   <= v1_d;
            dout_q <= dout_d;
            ov_q   <= ov_d;
`ifdef SINE_AMP_SHIFT_EN
            sh_q   <= sh_d;
`endif
        end
    end

    assign in_ready  = advance;
    assign dout      = dout_q;
    assign out_valid = ov_q;

endmodule

// File: doc/sine_lookup.md
SINE_LOOKUP -- requirements
Module: sine_lookup

Interface
REQ-001 SHALL have parameter ZERO_CODE, default 8'd128, the output code for zero amplitude; legal range 127..128.
REQ-002 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  phase word present this cycle; driven by the phase counter's enable.
REQ-005 SHALL have port phase  input  8  phase word from the upstream phase-accumulator counter's count output; 256 steps per period.
REQ-006 SHALL have port in_ready  output  1  phase word accepted when in_valid && in_ready.
REQ-007 SHALL have port dout  output  8  unsigned offset-binary sine sample.
REQ-008 SHALL have port out_valid  output  1  dout holds a valid sample.
REQ-009 SHALL have port out_ready  input  1  downstream accepts dout when out_valid && out_ready.

Function
REQ-010 SHALL hold a 65-entry quarter-wave table T[i] = round(127*sin(2*pi*i/256)), i = 0..64; T[0]=0, T[64]=127.
REQ-011 SHALL fold phase p: q=p[7:6], k=p[5:0]; addr = k for q=0 or 2, addr = 64-k for q=1 or 3.
REQ-012 SHALL form signed s = +T[addr] for q=0,1 and -T[addr] for q=2,3; s in -127..+127.
REQ-013 SHALL output dout = ZERO_CODE + s, evaluated at 9 bits; result never wraps for legal ZERO_CODE.
REQ-014 SHALL be a 2-stage pipeline: stage 1 registers fold result (addr, sign) and valid; stage 2 registers dout and out_valid.
REQ-015 SHALL have latency exactly 2 cycles from accepted phase to out_valid=1 with its sample when out_ready stays 1.
REQ-016 SHALL compute advance = !out_valid || out_ready; both stages load only when advance=1, otherwise hold all state.
REQ-017 SHALL drive in_ready = advance, combinationally.
REQ-018 SHALL load stage-1 valid with in_valid when advancing, so bubbles propagate as out_valid=0 cycles.
REQ-019 SHALL sustain one sample per cycle with out_ready=1 and in_valid=1 continuously.
REQ-020 SHALL keep dout and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL treat phase 255 -> 0 wrap as ordinary consecutive inputs; no discontinuity handling.

Reset
REQ-022 SHALL on rst=1 immediately clear both stage valids, so out_valid=0, in_ready=1.
REQ-023 SHALL on rst=1 set dout=ZERO_CODE and stage-1 addr/sign to 0.
REQ-024 SHALL discard in-flight samples when rst asserts mid-stream; the first sample after release is the first phase accepted after release.
REQ-025 SHALL not accept input while rst=1.

Configuration
REQ-026 SHALL, with macro SINE_AMP_SHIFT_EN defined, add port amp_shift  input  3  attenuation, sampled with the phase into stage 1.
REQ-027 SHALL, with SINE_AMP_SHIFT_EN defined, output dout = ZERO_CODE + (s >>> amp_shift), arithmetic shift, floor rounding.
REQ-028 SHALL, without SINE_AMP_SHIFT_EN, have no amp_shift port and behave as amp_shift=0.

Verification
REQ-029 SHALL test phases 0, 64, 128, 192 streamed with out_ready=1 -> dout 128, 255, 128, 1 on cycles 2..5 after first accept.
REQ-030 SHALL test symmetry for phases 32 and 96 -> equal dout (ZERO_CODE+T[32]=218); phases 160, 224 -> 38.
REQ-031 SHALL test stall: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, dout/out_valid frozen, no sample lost or duplicated.
REQ-032 SHALL test bubbles: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 after 2 cycles.
REQ-033 SHALL test async reset mid-stream between clock edges -> out_valid=0 and dout=128 before the next edge.
REQ-034 SHALL test, with SINE_AMP_SHIFT_EN, phase 64 and amp_shift=1 -> dout 191; phase 192 and amp_shift=7 -> dout 127.
